rev_counter_param: RTL and testbench

Parametrised reversible counter with built-in tick prescaler, synchronous load, configurable modulus and wrap/saturate mode. It is the next-generation replacement for the fixed 16-bit reversible counter that feeds the four-digit seven-segment display. It runs directly on the board clock, so no external clock divider is needed. `cnt` connects straight to the display's `HEXS` input, and `Rc` drives an LED.

---
 rtl/rev_counter_param.sv | 97 +++++++++
 tb/tb_rev_counter_param.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rev_counter_param.sv
`default_nettype none
// ============================================================================
// Module   : rev_counter_param
// Purpose  : Reversible up/down counter with tick prescaler, load, modulus and
//            wrap/saturate mode.
// Revision : 1.0 - initial release
// ============================================================================
module rev_counter_param #(
  parameter int unsigned      WIDTH    = 16,
  parameter logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}},
  parameter int unsigned      DIV      = 10_000_000,
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             RST_N,
  input  logic             en,
  input  logic             s,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] cnt,
  output logic             Rc,
  output logic             wrap,
  output logic             tick
);

  localparam int unsigned      DIV_W      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(DIV - 1);

  logic [WIDTH-1:0] r_cnt;
  logic             r_wrap;
  logic [DIV_W-1:0] r_div_cnt;

  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_wrap_nxt;
  logic [DIV_W-1:0] w_div_nxt;
  logic [WIDTH-1:0] w_din_clamped;
  logic             w_tick;
  logic             w_at_max;
  logic             w_at_zero;

  // Equality against MAX avoids any MAX+1 term that would overflow WIDTH bits.
  assign w_at_max      = (r_cnt == MAX);
  assign w_at_zero     = (r_cnt == '0);
  assign w_din_clamped = (din > MAX) ? MAX : din;
  assign w_tick        = en && (r_div_cnt == C_DIV_LAST);

  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_wrap_nxt = 1'b0;
    w_div_nxt  = r_div_cnt;
    if (load) begin
      w_cnt_nxt = w_din_clamped;
      w_div_nxt = '0;
    end else begin
      if (en) begin
        w_div_nxt = w_tick ? '0 : r_div_cnt + DIV_W'(1);
      end
      if (w_tick) begin
        if (s) begin
          if (!w_at_max) begin
            w_cnt_nxt = r_cnt + WIDTH'(1);
          end else if (!SATURATE) begin
            w_cnt_nxt  = '0;
            w_wrap_nxt = 1'b1;
          end
        end else begin
          if (!w_at_zero) begin
            w_cnt_nxt = r_cnt - WIDTH'(1);
          end else if (!SATURATE) begin
            w_cnt_nxt  = MAX;
            w_wrap_nxt = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt     <= '0;
      r_wrap    <= 1'b0;
      r_div_cnt <= '0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_wrap    <= w_wrap_nxt;
      r_div_cnt <= w_div_nxt;
    end
  end

  assign cnt  = r_cnt;
  assign wrap = r_wrap;
  assign tick = w_tick;
  // Terminal count tracks s without waiting for a clock edge.
  assign Rc   = s ? w_at_max : w_at_zero;

endmodule
`default_nettype wire

// File: tb/tb_rev_counter_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_rev_counter_param
// Purpose  : Scoreboard bench for rev_counter_param, wrap and saturate builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rev_counter_param;

  localparam int C_MAX = 9;
  localparam int C_DIV = 3;

  typedef struct {
    int cnt;
    int wrap;
    int rc;
    int tick;
  } exp_t;

  logic       clk;
  logic       RST_N;
  logic       en;
  logic       s;
  logic       load;
  logic [3:0] din;

  logic [3:0] cnt_w, cnt_s;
  logic       rc_w, rc_s, wrap_w, wrap_s, tick_w, tick_s;

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t q_w[$];
  exp_t q_s[$];

  // reference model state
  int m_cnt[2];
  int m_wrap[2];
  int m_phase;

  rev_counter_param #(.WIDTH(4), .MAX(4'd9), .DIV(C_DIV), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .RST_N(RST_N), .en(en), .s(s), .load(load), .din(din),
    .cnt(cnt_w), .Rc(rc_w), .wrap(wrap_w), .tick(tick_w)
  );

  rev_counter_param #(.WIDTH(4), .MAX(4'd9), .DIV(C_DIV), .SATURATE(1'b1)) u_sat (
    .clk(clk), .RST_N(RST_N), .en(en), .s(s), .load(load), .din(din),
    .cnt(cnt_s), .Rc(rc_s), .wrap(wrap_s), .tick(tick_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_phase = 0;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k]  = 0;
      m_wrap[k] = 0;
    end
  endtask

  // Apply inputs now and predict the state after the coming rising edge.
  task automatic drive_step(input logic e, input logic ss, input logic ld, input logic [3:0] d);
    bit   step;
    exp_t x;
    en = e; s = ss; load = ld; din = d;
    step = !ld && e && (m_phase == C_DIV - 1);
    for (int k = 0; k < 2; k++) begin
      m_wrap[k] = 0;
      if (ld) begin
        m_cnt[k] = (int'(d) > C_MAX) ? C_MAX : int'(d);
      end else if (step) begin
        if (ss) begin
          if (m_cnt[k] < C_MAX) m_cnt[k] = m_cnt[k] + 1;
          else if (k == 0) begin m_cnt[k] = 0; m_wrap[k] = 1; end
        end else begin
          if (m_cnt[k] > 0) m_cnt[k] = m_cnt[k] - 1;
          else if (k == 0) begin m_cnt[k] = C_MAX; m_wrap[k] = 1; end
        end
      end
    end
    if (ld) m_phase = 0;
    else if (e) m_phase = (m_phase + 1) % C_DIV;
    for (int k = 0; k < 2; k++) begin
      x.cnt  = m_cnt[k];
      x.wrap = m_wrap[k];
      x.rc   = ss ? int'(m_cnt[k] == C_MAX) : int'(m_cnt[k] == 0);
      x.tick = int'(e && (m_phase == C_DIV - 1));
      if (k == 0) q_w.push_back(x);
      else        q_s.push_back(x);
    end
  endtask

  task automatic cycle(input logic e, input logic ss, input logic ld, input logic [3:0] d);
    @(negedge clk);
    drive_step(e, ss, ld, d);
  endtask

  // Asynchronous reset pulse between edges; the edge that follows is normal.
  task automatic mid_reset(input logic e, input logic ss);
    @(negedge clk);
    RST_N = 1'b0;
    #1;
    chk("async_rst_cnt_w", int'(cnt_w), 0);
    chk("async_rst_cnt_s", int'(cnt_s), 0);
    chk("async_rst_wrap_w", int'(wrap_w), 0);
    chk("async_rst_rc_w", int'(rc_w), int'(!s));
    #1;
    RST_N = 1'b1;
    model_reset();
    drive_step(e, ss, 1'b0, 4'd0);
  endtask

  // Monitor: every clock the DUTs present a new state; compare against queue head.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q_w.size() > 0) begin
        x = q_w.pop_front();
        chk("cnt_wrapmode",  int'(cnt_w),  x.cnt);
        chk("wrap_wrapmode", int'(wrap_w), x.wrap);
        chk("rc_wrapmode",   int'(rc_w),   x.rc);
        chk("tick_wrapmode", int'(tick_w), x.tick);
      end
      if (q_s.size() > 0) begin
        x = q_s.pop_front();
        chk("cnt_satmode",  int'(cnt_s),  x.cnt);
        chk("wrap_satmode", int'(wrap_s), x.wrap);
        chk("rc_satmode",   int'(rc_s),   x.rc);
        chk("tick_satmode", int'(tick_s), x.tick);
      end
    end
  end

  initial begin
    bit   r_dir;
    logic r_en, r_ld;
    RST_N = 1'b0; en = 1'b0; s = 1'b0; load = 1'b0; din = 4'd0;
    #2;
    chk("rst_cnt",  int'(cnt_w), 0);
    chk("rst_wrap", int'(wrap_w), 0);
    chk("rst_rc_down", int'(rc_w), 1);
    chk("rst_tick", int'(tick_w), 0);
    s = 1'b1;
    #1;
    chk("rst_rc_up_noclk", int'(rc_w), 0);
    chk("rst_rc_up_noclk_sat", int'(rc_s), 0);
    model_reset();
    RST_N = 1'b1;

    // Up count through 9 -> 0 (saturating build sticks at 9).
    repeat (30) cycle(1'b1, 1'b1, 1'b0, 4'd0);
    // Down from 0: wrap to 9, then 8.
    repeat (6) cycle(1'b1, 1'b0, 1'b0, 4'd0);
    // Load clamp, then load colliding with a tick.
    cycle(1'b1, 1'b1, 1'b1, 4'd12);
    repeat (2) cycle(1'b1, 1'b1, 1'b0, 4'd0);
    cycle(1'b1, 1'b1, 1'b1, 4'd5);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 4'd0);
    // Load while disabled.
    cycle(1'b0, 1'b1, 1'b1, 4'd3);
    // Freeze at phase 1, resume.
    cycle(1'b1, 1'b1, 1'b0, 4'd0);
    repeat (10) cycle(1'b0, 1'b1, 1'b0, 4'd0);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 4'd0);
    // Down at 0 in both builds.
    cycle(1'b1, 1'b0, 1'b1, 4'd0);
    repeat (7) cycle(1'b1, 1'b0, 1'b0, 4'd0);
    // Reset mid-count, then phase restarts.
    mid_reset(1'b1, 1'b1);
    repeat (5) cycle(1'b1, 1'b1, 1'b0, 4'd0);

    r_dir = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 11) == 0) r_dir = ~r_dir;
      r_en = ($urandom_range(0, 9) < 8);
      r_ld = ($urandom_range(0, 24) == 0);
      if (i == 200) mid_reset(r_en, r_dir);
      else cycle(r_en, r_dir, r_ld, 4'($urandom_range(0, 15)));
    end

    repeat (2) @(negedge clk);
    chk("queue_drained_w", q_w.size(), 0);
    chk("queue_drained_s", q_s.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
